uart_rx_deser: RTL and testbench

UART_RX_DESER -- requirements
Module: uart_rx_deser

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync2.sv | 21 ++
 rtl/uart_rx_deser.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_deser.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM states, word-length codes, tick thresholds.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam logic [3:0] TICK_MID = 4'd7;
  localparam logic [3:0] TICK_END = 4'd15;

  // Index of the final data bit for a given word-length code.
  function automatic logic [2:0] wls_last(input logic [1:0] wls);
    case (wls)
      WLS_5:   wls_last = 3'd4;
      WLS_6:   wls_last = 3'd5;
      WLS_7:   wls_last = 3'd6;
      default: wls_last = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 (line idle).
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 16x oversampled, 5-8 data bits, one stop bit.
// Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_deser
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bclk_en,
  input  logic       rx_in,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  output logic [7:0] shift_data,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  uart_state_e state, state_n;
  logic       rx_s;
  logic [3:0] tick;
  logic [2:0] bitcnt;
  logic [7:0] sr;
  logic [1:0] wls_q;
  logic       tick_clr, start_ok, shift_en, stop_smp;
  logic       unused_cfg;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic pen_q, eps_q, par, perr_q, par_smp;
`endif

  assign rx_busy    = (state != IDLE);
  assign unused_cfg = ^{PEN, EPS};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tick_clr = 1'b0;
    start_ok = 1'b0;
    shift_en = 1'b0;
    stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n  = START;
          tick_clr = 1'b1;
        end
      end
      START: begin
        if (bclk_en && tick == TICK_MID) begin
          if (!rx_s) begin
            start_ok = 1'b1;
            tick_clr = 1'b1;
            state_n  = DATA;
          end else begin
            state_n  = IDLE;
          end
        end
      end
      DATA: begin
        if (bclk_en && tick == TICK_END) begin
          shift_en = 1'b1;
          if (bitcnt == wls_last(wls_q)) begin
`ifdef UART_RX_PARITY_EN
            state_n = pen_q ? PARITY : STOP;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bclk_en && tick == TICK_END) begin
          par_smp = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (bclk_en && tick == TICK_END) begin
          stop_smp = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick   <= '0;
      bitcnt <= '0;
    end else begin
      if (tick_clr)     tick <= '0;
      else if (bclk_en) tick <= tick + 4'd1;
      if (start_ok)      bitcnt <= '0;
      else if (shift_en) bitcnt <= bitcnt + 3'd1;
    end
  end

  // sr is cleared at frame start so short words leave zeros below the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr         <= '0;
      wls_q      <= '0;
      shift_data <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (start_ok) begin
        wls_q <= WLS;
        sr    <= '0;
      end else if (shift_en) begin
        sr <= {rx_s, sr[7:1]};
      end
      if (stop_smp) begin
        shift_data <= sr;
        frame_err  <= ~rx_s;
        rx_done    <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      par        <= 1'b0;
      perr_q     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (start_ok) begin
        pen_q  <= PEN;
        eps_q  <= EPS;
        par    <= 1'b0;
        perr_q <= 1'b0;
      end else if (shift_en) begin
        par <= par ^ rx_s;
      end
      if (par_smp) perr_q <= eps_q ? (par ^ rx_s) : ~(par ^ rx_s);
      if (stop_smp) parity_err <= pen_q & perr_q;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: scoreboard of expected frames checked on rx_done.
module tb_uart_rx_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bclk_en = 1'b0;
  logic       rx_in = 1'b1;
  logic [1:0] WLS = 2'b11;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic [7:0] shift_data;
  logic       rx_done, parity_err, frame_err, rx_busy;

  typedef struct packed {
    logic [7:0] sd;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  logic       prev_done = 1'b0;
  logic [7:0] last_sd = 8'h00;
  logic [1:0] bcnt = 2'd0;

  uart_rx_deser dut (
    .clk        (clk),
    .rst        (rst),
    .bclk_en    (bclk_en),
    .rx_in      (rx_in),
    .WLS        (WLS),
    .PEN        (PEN),
    .EPS        (EPS),
    .shift_data (shift_data),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    bcnt    <= bcnt + 2'd1;
    bclk_en <= (bcnt == 2'd3);
  end

  // Scoreboard monitor: every rx_done pops one expected frame.
  always @(negedge clk) begin
    if (!rst && rx_done) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (prev_done) begin
        failures++;
        $display("FAIL done_pulse_width: rx_done high on consecutive clocks, required single clk");
      end
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: rx_done with no frame expected, shift_data=%h", shift_data);
      end else begin
        e = exp_q.pop_front();
        checks += 3;
        if (shift_data !== e.sd) begin
          failures++;
          $display("FAIL shift_data: got %h required %h", shift_data, e.sd);
        end
        if (parity_err !== e.pe) begin
          failures++;
          $display("FAIL parity_err: got %b required %b", parity_err, e.pe);
        end
        if (frame_err !== e.fe) begin
          failures++;
          $display("FAIL frame_err: got %b required %b", frame_err, e.fe);
        end
      end
    end
    prev_done <= rx_done;
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!bclk_en) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input int n, input bit with_par,
                            input bit par_bit, input bit stop_bit, input bit scramble);
    exp_t       e;
    logic [7:0] m;
    logic [1:0] wls_save;
    logic       pen_save, eps_save;
    m    = data & 8'((1 << n) - 1);
    e.sd = m << (8 - n);
`ifdef UART_RX_PARITY_EN
    e.pe = with_par ? (EPS ? ^{m, par_bit} : ~^{m, par_bit}) : 1'b0;
`else
    e.pe = 1'b0;
`endif
    e.fe = ~stop_bit;
    exp_q.push_back(e);
    last_sd  = e.sd;
    wls_save = WLS;
    pen_save = PEN;
    eps_save = EPS;
    rx_in = 1'b0;
    wait_ticks(16);
    if (scramble) begin
      WLS = ~WLS;
      PEN = ~PEN;
      EPS = ~EPS;
    end
    for (int i = 0; i < n; i++) begin
      rx_in = data[i];
      wait_ticks(16);
    end
    if (with_par) begin
      rx_in = par_bit;
      wait_ticks(16);
    end
    rx_in = stop_bit;
    if (stop_bit) begin
      wait_ticks(16);
    end else begin
      wait_ticks(12);
      rx_in = 1'b1;
      wait_ticks(4);
    end
    WLS = wls_save;
    PEN = pen_save;
    EPS = eps_save;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d frames still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({shift_data, rx_done, parity_err, frame_err, rx_busy} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state: sd=%h done=%b pe=%b fe=%b busy=%b required all zero",
               shift_data, rx_done, parity_err, frame_err, rx_busy);
    end
    rst = 1'b0;
    wait_ticks(20);
  endtask

  task automatic test_8bit();
    int d0 = done_cnt;
    WLS = 2'b11; PEN = 1'b0;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done("frame_55");
    checks++;
    if (done_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL done_count_55: got %0d required %0d", done_cnt, d0 + 1);
    end
  endtask

  task automatic test_5bit();
    WLS = 2'b00; PEN = 1'b0;
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done("frame_5bit");
  endtask

  task automatic test_false_start();
    int d0 = done_cnt;
    rx_in = 1'b0;
    wait_ticks(2);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL false_start_busy: got %b required 1", rx_busy);
    end
    wait_ticks(2);
    rx_in = 1'b1;
    wait_ticks(32);
    checks += 3;
    if (rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL false_start_idle: rx_busy got %b required 0", rx_busy);
    end
    if (done_cnt !== d0) begin
      failures++;
      $display("FAIL false_start_done: count got %0d required %0d", done_cnt, d0);
    end
    if (shift_data !== last_sd) begin
      failures++;
      $display("FAIL false_start_hold: shift_data got %h required %h", shift_data, last_sd);
    end
  endtask

  task automatic test_parity();
    WLS = 2'b11; PEN = 1'b1; EPS = 1'b1;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done("even_bad");
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_done("even_good");
    EPS = 1'b0;
    send_frame(8'h01, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done("odd_good");
    send_frame(8'h03, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_done("odd_bad");
`else
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done("parity_ignored");
`endif
    PEN = 1'b0; EPS = 1'b0;
  endtask

  task automatic test_frame_err();
    WLS = 2'b11; PEN = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done("stop_low");
    wait_ticks(32);
    checks++;
    if (frame_err !== 1'b1 || shift_data !== 8'hA5) begin
      failures++;
      $display("FAIL frame_err_hold: fe=%b sd=%h required fe=1 sd=a5", frame_err, shift_data);
    end
  endtask

  task automatic test_cfg_change();
    WLS = 2'b11; PEN = 1'b0; EPS = 1'b0;
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done("cfg_change");
  endtask

  task automatic test_back_to_back();
    WLS = 2'b01;
    send_frame(8'h2A, 6, 1'b0, 1'b0, 1'b1, 1'b0);
    WLS = 2'b10;
    send_frame(8'h5B, 7, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done("back_to_back");
  endtask

  task automatic test_reset_midframe();
    int d0;
    WLS = 2'b11; PEN = 1'b0;
    rx_in = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx_in = 1'b1;
      wait_ticks(16);
    end
    rx_in = 1'b0;
    wait_ticks(8);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({shift_data, rx_done, parity_err, frame_err, rx_busy} !== 12'h000) begin
      failures++;
      $display("FAIL midframe_reset: sd=%h done=%b pe=%b fe=%b busy=%b required all zero",
               shift_data, rx_done, parity_err, frame_err, rx_busy);
    end
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    d0 = done_cnt;
    wait_ticks(40);
    checks++;
    if (done_cnt !== d0 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL discard_partial: done count %0d busy %b required %0d and 0", done_cnt, rx_busy, d0);
    end
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done("after_reset");
    checks++;
    if (done_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL after_reset_done: count got %0d required %0d", done_cnt, d0 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_8bit();
    test_5bit();
    test_false_start();
    test_parity();
    test_frame_err();
    test_cfg_change();
    test_back_to_back();
    test_reset_midframe();
    wait_ticks(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
